// File: rtl/z80_bus_responder.sv
// Synthesizable posedge bus slave for the tv80s external bus: memory/IO decode,
// backing RAM and IO port access, interrupt-acknowledge vector and wait-state insertion.
module z80_bus_responder #(
  parameter int         MEM_WAIT   = 0,
  parameter int         IO_WAIT    = 1,
  parameter logic [7:0] INTACK_VEC = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_do,
  output logic [7:0]  cpu_di,
  input  logic        cpu_mreq_n,
  input  logic        cpu_iorq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic        cpu_m1_n,
  input  logic        cpu_rfsh_n,
  output logic        cpu_wait_n,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  io_addr,
  output logic        io_we,
  output logic [7:0]  io_wdata,
  input  logic [7:0]  io_rdata,
  output logic [15:0] m1_count
);

  typedef enum logic [2:0] {IDLE, RD, WR, WAIT, DONE} state_t;

  localparam logic [3:0] MEM_N = 4'(MEM_WAIT);
  localparam logic [3:0] IO_N  = 4'(IO_WAIT);

  state_t     state_q, state_d;
  logic [3:0] wait_cnt;
  logic       is_io;
  logic       take_intack, take_rd, take_wr, take_io;
  logic [3:0] load_n;

  assign load_n = take_io ? IO_N : MEM_N;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Decode priority: refresh, int-ack, memory read/write, then IO (memory wins a clash).
  always_comb begin
    state_d     = state_q;
    take_intack = 1'b0;
    take_rd     = 1'b0;
    take_wr     = 1'b0;
    take_io     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!(!cpu_mreq_n && !cpu_rfsh_n)) begin
          if (!cpu_iorq_n && !cpu_m1_n) begin
            take_intack = 1'b1;
            state_d     = DONE;
          end else if (!cpu_mreq_n && !cpu_rd_n) begin
            take_rd = 1'b1;
            state_d = RD;
          end else if (!cpu_mreq_n && !cpu_wr_n) begin
            take_wr = 1'b1;
            state_d = WR;
          end else if (cpu_mreq_n && !cpu_iorq_n && !cpu_rd_n) begin
            take_rd = 1'b1;
            take_io = 1'b1;
            state_d = RD;
          end else if (cpu_mreq_n && !cpu_iorq_n && !cpu_wr_n) begin
            take_wr = 1'b1;
            take_io = 1'b1;
            state_d = WR;
          end
        end
      end
      RD, WR:  state_d = (wait_cnt > 4'd1) ? WAIT : DONE;
      WAIT:    if (wait_cnt <= 4'd1) state_d = DONE;
      DONE:    if (cpu_mreq_n && cpu_iorq_n) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_di     <= 8'hFF;
      cpu_wait_n <= 1'b1;
      mem_addr   <= 16'h0000;
      mem_we     <= 1'b0;
      mem_wdata  <= 8'h00;
      io_addr    <= 8'h00;
      io_we      <= 1'b0;
      io_wdata   <= 8'h00;
      m1_count   <= 16'h0000;
      wait_cnt   <= 4'd0;
      is_io      <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      io_we  <= 1'b0;
      if (state_q == IDLE) begin
        if (take_intack) cpu_di <= INTACK_VEC;
        if (take_rd || take_wr) begin
          is_io    <= take_io;
          wait_cnt <= load_n;
          if (load_n != 4'd0) cpu_wait_n <= 1'b0;
          if (take_io) begin
            io_addr <= cpu_a[7:0];
            if (take_wr) io_wdata <= cpu_do;
          end else begin
            mem_addr <= cpu_a;
            if (take_wr) mem_wdata <= cpu_do;
            if (take_rd && !cpu_m1_n) m1_count <= m1_count + 16'd1;
          end
        end
      end else if (state_q != DONE) begin
        // The wait counter runs out in RD/WR/WAIT regardless of what the strobes do.
        if (wait_cnt != 4'd0) begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) cpu_wait_n <= 1'b1;
        end
        if (state_q == RD) cpu_di <= is_io ? io_rdata : mem_rdata;
        if (state_q == WR) begin
          mem_we <= !is_io;
          io_we  <= is_io;
        end
      end
    end
  end

endmodule

// File: tb/tb_z80_bus_responder.sv
// Directed bench for z80_bus_responder: three instances (MEM_WAIT 0/3/5, IO_WAIT 1)
// share one CPU stimulus; each task checks the instance relevant to its scenario.
module tb_z80_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_do;
  logic        cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n, cpu_rfsh_n;

  logic [7:0]  cpu_di     [3];
  logic        cpu_wait_n [3];
  logic [15:0] mem_addr   [3];
  logic        mem_we     [3];
  logic [7:0]  mem_wdata  [3];
  logic [7:0]  mem_rdata  [3];
  logic [7:0]  io_addr    [3];
  logic        io_we      [3];
  logic [7:0]  io_wdata   [3];
  logic [7:0]  io_rdata   [3];
  logic [15:0] m1_count   [3];

  logic [7:0]  ram      [65536];
  logic [7:0]  io_space [256];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    z80_bus_responder #(
      .MEM_WAIT  (g == 0 ? 0 : (g == 1 ? 3 : 5)),
      .IO_WAIT   (1),
      .INTACK_VEC(8'hFF)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_a     (cpu_a),
      .cpu_do    (cpu_do),
      .cpu_di    (cpu_di[g]),
      .cpu_mreq_n(cpu_mreq_n),
      .cpu_iorq_n(cpu_iorq_n),
      .cpu_rd_n  (cpu_rd_n),
      .cpu_wr_n  (cpu_wr_n),
      .cpu_m1_n  (cpu_m1_n),
      .cpu_rfsh_n(cpu_rfsh_n),
      .cpu_wait_n(cpu_wait_n[g]),
      .mem_addr  (mem_addr[g]),
      .mem_we    (mem_we[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g]),
      .io_addr   (io_addr[g]),
      .io_we     (io_we[g]),
      .io_wdata  (io_wdata[g]),
      .io_rdata  (io_rdata[g]),
      .m1_count  (m1_count[g])
    );
    assign mem_rdata[g] = ram[mem_addr[g]];
    assign io_rdata[g]  = io_space[io_addr[g]];
  end

  always @(posedge clk) if (io_we[0]) io_space[io_addr[0]] <= io_wdata[0];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_strobes();
    cpu_mreq_n = 1'b1; cpu_iorq_n = 1'b1; cpu_rd_n = 1'b1;
    cpu_wr_n   = 1'b1; cpu_m1_n   = 1'b1; cpu_rfsh_n = 1'b1;
  endtask

  task automatic settle();
    idle_strobes();
    for (int i = 0; i < 8; i++) step();
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_a = 16'h0000; cpu_do = 8'h00; idle_strobes();
    step(); step();
    checks++; if (cpu_di[0] !== 8'hFF) begin errors++; $display("[TB] FAIL reset_cpu_di got=%h exp=FF", cpu_di[0]); end
    checks++; if (cpu_wait_n[0] !== 1'b1) begin errors++; $display("[TB] FAIL reset_wait_n got=%b exp=1", cpu_wait_n[0]); end
    checks++; if (mem_we[0] !== 1'b0 || io_we[0] !== 1'b0) begin errors++; $display("[TB] FAIL reset_we got=%b%b exp=00", mem_we[0], io_we[0]); end
    checks++; if (mem_addr[0] !== 16'h0000 || io_addr[0] !== 8'h00) begin errors++; $display("[TB] FAIL reset_addr got=%h/%h exp=0000/00", mem_addr[0], io_addr[0]); end
    checks++; if (mem_wdata[0] !== 8'h00 || io_wdata[0] !== 8'h00) begin errors++; $display("[TB] FAIL reset_wdata got=%h/%h exp=00/00", mem_wdata[0], io_wdata[0]); end
    checks++; if (m1_count[0] !== 16'h0000) begin errors++; $display("[TB] FAIL reset_m1_count got=%h exp=0000", m1_count[0]); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_zero_wait_fetch();
    logic [7:0] exp_b [4];
    int wait_low, we_seen;
    exp_b = '{8'hFD, 8'hCB, 8'h2E, 8'h59};
    wait_low = 0; we_seen = 0;
    for (int k = 0; k < 4; k++) begin
      cpu_a = 16'(k); cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0; cpu_m1_n = 1'b0;
      for (int c = 0; c < 4; c++) begin
        step();
        if (cpu_wait_n[0] === 1'b0) wait_low++;
        if (mem_we[0] === 1'b1) we_seen++;
        if (c == 1) begin
          checks++; if (cpu_di[0] !== exp_b[k]) begin errors++; $display("[TB] FAIL fetch_data[%0d] got=%h exp=%h", k, cpu_di[0], exp_b[k]); end
          idle_strobes();
        end
      end
    end
    cpu_a = 16'hFB01; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
    step(); step();
    checks++; if (cpu_di[0] !== 8'h6F) begin errors++; $display("[TB] FAIL data_read_FB01 got=%h exp=6F", cpu_di[0]); end
    checks++; if (m1_count[0] !== 16'd4) begin errors++; $display("[TB] FAIL fetch_m1_count got=%0d exp=4", m1_count[0]); end
    checks++; if (wait_low != 0) begin errors++; $display("[TB] FAIL zero_wait_low got=%0d exp=0", wait_low); end
    checks++; if (we_seen != 0) begin errors++; $display("[TB] FAIL fetch_mem_we got=%0d exp=0", we_seen); end
    settle();
  endtask

  task automatic test_mem_write();
    int pulses, pulse_at;
    logic [15:0] p_addr;
    logic [7:0]  p_data;
    pulses = 0; pulse_at = 0; p_addr = 16'h0; p_data = 8'h0;
    cpu_a = 16'h1234; cpu_do = 8'hA5; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (mem_we[0] === 1'b1) begin pulses++; pulse_at = i; p_addr = mem_addr[0]; p_data = mem_wdata[0]; end
    end
    checks++; if (pulses != 1) begin errors++; $display("[TB] FAIL write_pulses got=%0d exp=1", pulses); end
    checks++; if (pulse_at != 2) begin errors++; $display("[TB] FAIL write_pulse_clk got=%0d exp=2", pulse_at); end
    checks++; if (p_addr !== 16'h1234 || p_data !== 8'hA5) begin errors++; $display("[TB] FAIL write_addr_data got=%h/%h exp=1234/A5", p_addr, p_data); end
    settle();
  endtask

  task automatic test_mem_wait();
    int low [3];
    logic first1, last1;
    low = '{0, 0, 0}; first1 = 1'b1; last1 = 1'b0;
    cpu_a = 16'h8000; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      for (int g = 0; g < 3; g++) if (cpu_wait_n[g] === 1'b0) low[g]++;
      if (i == 1) first1 = cpu_wait_n[1];
      if (i == 4) last1 = cpu_wait_n[1];
    end
    checks++; if (low[0] != 0) begin errors++; $display("[TB] FAIL wait0_low got=%0d exp=0", low[0]); end
    checks++; if (low[1] != 3) begin errors++; $display("[TB] FAIL wait3_low got=%0d exp=3", low[1]); end
    checks++; if (low[2] != 5) begin errors++; $display("[TB] FAIL wait5_low got=%0d exp=5", low[2]); end
    checks++; if (first1 !== 1'b0 || last1 !== 1'b1) begin errors++; $display("[TB] FAIL wait3_edges got=%b%b exp=01", first1, last1); end
    checks++; if (cpu_di[1] !== 8'h3C || cpu_di[2] !== 8'h3C) begin errors++; $display("[TB] FAIL wait_read_data got=%h/%h exp=3C/3C", cpu_di[1], cpu_di[2]); end
    idle_strobes(); step(); step();
    cpu_a = 16'h8001; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
    step();
    checks++; if (cpu_wait_n[1] !== 1'b0) begin errors++; $display("[TB] FAIL wait3_redecode got=%b exp=0", cpu_wait_n[1]); end
    step(); step(); step();
    checks++; if (cpu_di[1] !== 8'hC3 || cpu_wait_n[1] !== 1'b1) begin errors++; $display("[TB] FAIL wait3_second_read got=%h/%b exp=C3/1", cpu_di[1], cpu_wait_n[1]); end
    settle();
  endtask

  task automatic test_io();
    int pulses, low, mem_pulses;
    logic [7:0] p_addr, p_data;
    pulses = 0; low = 0; mem_pulses = 0; p_addr = 8'h0; p_data = 8'h0;
    cpu_a = 16'h337F; cpu_do = 8'h55; cpu_iorq_n = 1'b0; cpu_wr_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (io_we[0] === 1'b1) begin pulses++; p_addr = io_addr[0]; p_data = io_wdata[0]; end
      if (mem_we[0] === 1'b1) mem_pulses++;
      if (cpu_wait_n[0] === 1'b0) low++;
    end
    checks++; if (pulses != 1 || mem_pulses != 0) begin errors++; $display("[TB] FAIL io_write_pulses got=%0d/%0d exp=1/0", pulses, mem_pulses); end
    checks++; if (p_addr !== 8'h7F || p_data !== 8'h55) begin errors++; $display("[TB] FAIL io_write_addr_data got=%h/%h exp=7F/55", p_addr, p_data); end
    checks++; if (low != 1) begin errors++; $display("[TB] FAIL io_write_wait got=%0d exp=1", low); end
    idle_strobes(); step(); step();
    low = 0;
    cpu_iorq_n = 1'b0; cpu_rd_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (cpu_wait_n[0] === 1'b0) low++;
    end
    checks++; if (low != 1) begin errors++; $display("[TB] FAIL io_read_wait got=%0d exp=1", low); end
    checks++; if (cpu_di[0] !== 8'h55) begin errors++; $display("[TB] FAIL io_read_data got=%h exp=55", cpu_di[0]); end
    settle();
  endtask

  task automatic test_intack_refresh();
    int we_seen, low;
    we_seen = 0; low = 0;
    cpu_iorq_n = 1'b0; cpu_m1_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (mem_we[0] === 1'b1 || io_we[0] === 1'b1) we_seen++;
      if (cpu_wait_n[0] === 1'b0) low++;
    end
    checks++; if (cpu_di[0] !== 8'hFF) begin errors++; $display("[TB] FAIL intack_vector got=%h exp=FF", cpu_di[0]); end
    checks++; if (we_seen != 0 || low != 0) begin errors++; $display("[TB] FAIL intack_activity got=%0d/%0d exp=0/0", we_seen, low); end
    idle_strobes(); step(); step(); step();
    cpu_a = 16'h0002; cpu_mreq_n = 1'b0; cpu_rfsh_n = 1'b0; cpu_rd_n = 1'b0; cpu_m1_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (mem_we[0] === 1'b1 || io_we[0] === 1'b1) we_seen++;
      if (cpu_wait_n[0] === 1'b0) low++;
    end
    checks++; if (m1_count[0] !== 16'd4) begin errors++; $display("[TB] FAIL refresh_m1_count got=%0d exp=4", m1_count[0]); end
    checks++; if (cpu_di[0] !== 8'hFF || mem_addr[0] !== 16'h8001) begin errors++; $display("[TB] FAIL refresh_ignored got=%h/%h exp=FF/8001", cpu_di[0], mem_addr[0]); end
    checks++; if (we_seen != 0 || low != 0) begin errors++; $display("[TB] FAIL refresh_activity got=%0d/%0d exp=0/0", we_seen, low); end
    settle();
  endtask

  task automatic test_illegal_overlap();
    cpu_a = 16'h4567; cpu_mreq_n = 1'b0; cpu_iorq_n = 1'b0; cpu_rd_n = 1'b0;
    step(); step();
    checks++; if (mem_addr[0] !== 16'h4567 || io_addr[0] !== 8'h7F) begin errors++; $display("[TB] FAIL overlap_addr got=%h/%h exp=4567/7F", mem_addr[0], io_addr[0]); end
    checks++; if (cpu_di[0] !== 8'h9A) begin errors++; $display("[TB] FAIL overlap_data got=%h exp=9A", cpu_di[0]); end
    settle();
  endtask

  task automatic test_back_to_back();
    cpu_a = 16'h0001; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
    step(); step();
    checks++; if (cpu_di[0] !== 8'hCB) begin errors++; $display("[TB] FAIL b2b_first got=%h exp=CB", cpu_di[0]); end
    idle_strobes(); step();
    cpu_a = 16'h0002; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
    step(); step();
    checks++; if (cpu_di[0] !== 8'h2E || mem_addr[0] !== 16'h0002) begin errors++; $display("[TB] FAIL b2b_second got=%h/%h exp=2E/0002", cpu_di[0], mem_addr[0]); end
    settle();
  endtask

  task automatic test_reset_mid();
    int we_seen, low;
    cpu_a = 16'hABCD; cpu_do = 8'h11; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
    step(); step();
    checks++; if (mem_we[2] !== 1'b1 || cpu_wait_n[2] !== 1'b0) begin errors++; $display("[TB] FAIL mid_pre_reset got=%b/%b exp=1/0", mem_we[2], cpu_wait_n[2]); end
    reset = 1'b1;
    #1;
    checks++; if (mem_we[2] !== 1'b0 || cpu_wait_n[2] !== 1'b1) begin errors++; $display("[TB] FAIL mid_async_reset got=%b/%b exp=0/1", mem_we[2], cpu_wait_n[2]); end
    checks++; if (m1_count[2] !== 16'h0000 || mem_addr[2] !== 16'h0000) begin errors++; $display("[TB] FAIL mid_reset_values got=%h/%h exp=0000/0000", m1_count[2], mem_addr[2]); end
    idle_strobes(); step(); reset = 1'b0; step();
    cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
    step();
    reset = 1'b1; idle_strobes();
    step(); step();
    reset = 1'b0;
    we_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      for (int g = 0; g < 3; g++) if (mem_we[g] === 1'b1) we_seen++;
    end
    checks++; if (we_seen != 0) begin errors++; $display("[TB] FAIL pending_write_discarded got=%0d exp=0", we_seen); end
    low = 0;
    cpu_a = 16'h8000; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0; cpu_m1_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (cpu_wait_n[2] === 1'b0) low++;
    end
    checks++; if (low != 5) begin errors++; $display("[TB] FAIL post_reset_wait got=%0d exp=5", low); end
    checks++; if (cpu_di[2] !== 8'h3C || m1_count[2] !== 16'd1) begin errors++; $display("[TB] FAIL post_reset_read got=%h/%0d exp=3C/1", cpu_di[2], m1_count[2]); end
    settle();
  endtask

  initial begin
    ram[16'h0000] = 8'hFD; ram[16'h0001] = 8'hCB; ram[16'h0002] = 8'h2E; ram[16'h0003] = 8'h59;
    ram[16'hFB01] = 8'h6F; ram[16'h8000] = 8'h3C; ram[16'h8001] = 8'hC3; ram[16'h4567] = 8'h9A;
    $display("[TB] starting z80_bus_responder bench");
    test_reset();
    test_zero_wait_fetch();
    test_mem_write();
    test_mem_wait();
    test_io();
    test_intack_refresh();
    test_illegal_overlap();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/z80_bus_responder.md
Name: z80_bus_responder

Overview:
- Memory/IO responder for the tv80s external bus: decodes mreq_n/iorq_n/rd_n/wr_n/m1_n/rfsh_n cycles from the CPU.
- Services them from a synchronous backing RAM port and a 256-entry IO port, returns read data on cpu_di, and inserts programmable wait states through cpu_wait_n.
- Replaces the behavioural negedge memory model in CPU benches and FPGA tops with a synthesizable posedge slave.

Parameters:
MEM_WAIT, 0, extra wait cycles per memory read/write (0..15)
IO_WAIT, 1, extra wait cycles per IO read/write (0..15)
INTACK_VEC, 8'hFF, byte returned on interrupt-acknowledge cycles (m1_n=0 & iorq_n=0)

Ports:
clk  in  1  CPU clock, all state on rising edge
reset  in  1  asynchronous, active-high
cpu_a  in  16  CPU address
cpu_do  in  8  CPU write data
cpu_di  out  8  read data to CPU
cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n, cpu_rfsh_n  in  1 each  CPU strobes
cpu_wait_n  out  1  wait request to CPU, low = stretch
mem_addr  out  16  backing RAM address
mem_we  out  1  backing RAM write strobe, one clk
mem_wdata  out  8  backing RAM write data
mem_rdata  in  8  backing RAM read data, valid 1 clk after mem_addr
io_addr  out  8  IO port address
io_we  out  1  IO write strobe, one clk
io_wdata  out  8  IO write data
io_rdata  in  8  IO read data, valid 1 clk after io_addr
m1_count  out  16  opcode fetch counter

Behaviour:
- Reset values: cpu_di=8'hFF, cpu_wait_n=1, mem_we=0, io_we=0, mem_addr=0, io_addr=0, mem_wdata=0, io_wdata=0, m1_count=0, state=IDLE.
- States: IDLE, RD, WR, WAIT, DONE.
- Decode in IDLE, in priority order, sampled at posedge:
  - refresh (mreq_n=0 & rfsh_n=0): ignored, stay IDLE.
  - int-ack (iorq_n=0 & m1_n=0): cpu_di<=INTACK_VEC, no port access, go to DONE.
  - mem read (mreq_n=0 & rd_n=0): mem_addr<=cpu_a; go to RD. If m1_n=0, m1_count increments (wraps FFFF->0000).
  - mem write (mreq_n=0 & wr_n=0): latch mem_addr=cpu_a and mem_wdata=cpu_do; go to WR.
  - io read/write: same as memory, using io_addr=cpu_a[7:0] and the io_* port.
  - mreq_n=0 & iorq_n=0 at once (illegal): memory wins.
- Wait count N = MEM_WAIT or IO_WAIT, chosen by space:
  - N>0: cpu_wait_n<=0 at the decode edge; counter loads N and decrements each clk.
  - cpu_wait_n<=1 on the edge where the counter reaches 0.
  - cpu_wait_n is low for exactly N clks.
- RD:
  - Next edge: cpu_di<=mem_rdata or io_rdata.
  - Go to WAIT if the counter is nonzero, else DONE.
  - cpu_di holds its value until the next read or int-ack capture.
- WR:
  - Next edge: mem_we or io_we =1 for exactly one clk with the latched addr/data.
  - Then go to WAIT or DONE.
  - Exactly one write per strobe assertion, however long wr_n stays low.
- WAIT: stays until the counter reaches 0, then DONE.
- DONE:
  - Stays until mreq_n=1 and iorq_n=1, then IDLE.
  - Back-to-back cycles therefore need at least one clk with strobes high.
  - Strobes that change during DONE are ignored.
- A strobe released early, during RD/WR/WAIT: the cycle completes internally (write still issued, counter runs out), then DONE→IDLE.
- Reset mid-operation:
  - Immediate return to reset values.
  - A pending write is discarded.
  - cpu_wait_n releases asynchronously.
- Zero-wait latency: decode edge plus one clk to valid cpu_di. This fits a tv80s T2/T3 read with wait_n never dropping.

Test Plan:
1. MEM_WAIT=0; preload RAM[0000..0003]=FD CB 2E 59, RAM[FB01]=6F; run tv80s with IY=FAD3, A=80, F=56 from PC=0000 → after the instruction PC=0004, F=38, A=80; cpu_wait_n never low; mem_we never pulses.
2. Directed mem write: cpu_a=1234, cpu_do=A5, mreq_n=wr_n=0 held 5 clks → mem_we high exactly 1 clk with mem_addr=1234, mem_wdata=A5; no second pulse.
3. MEM_WAIT=3, mem read at 8000 with RAM=3C → cpu_wait_n low exactly 3 clks from the decode edge; cpu_di=3C; state returns IDLE after mreq_n rises.
4. IO_WAIT=1: OUT to port 7F data 55, then IN from 7F → io_we one pulse (io_addr=7F, io_wdata=55); cpu_di=55 on read; cpu_wait_n low 1 clk each cycle.
5. Int-ack (m1_n=0, iorq_n=0) with INTACK_VEC=FF → cpu_di=FF, no mem_we/io_we. Refresh cycle (mreq_n=0, rfsh_n=0) → no port activity, m1_count unchanged.
6. Assert reset during WAIT of a MEM_WAIT=5 write → cpu_wait_n=1 and mem_we=0 immediately; m1_count=0; the next read after release is serviced normally.
